// File: rtl/adsb_ppm_decoder.sv
// Mode S preamble detector and PPM bit slicer for a magnitude stream at SAMPLES_PER_CHIP
// samples per chip. The message length (56 or 112 bits) is chosen from the DF field.
module adsb_ppm_decoder #(
  parameter int unsigned MAG_WIDTH        = 16,
  parameter int unsigned SAMPLES_PER_CHIP = 2,
  parameter int unsigned THRESHOLD_WIDTH  = 24,
  parameter int unsigned SCORE_WIDTH      = MAG_WIDTH + $clog2(SAMPLES_PER_CHIP) + 6
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Mag_valid,
  input  logic [MAG_WIDTH-1:0]          Mag_data,
  input  logic                          Cfg_enable,
  input  logic [THRESHOLD_WIDTH-1:0]    Cfg_threshold,
  output logic                          Msg_valid,
  output logic                          Msg_long,
  output logic [111:0]                  Msg_data,
  output logic signed [SCORE_WIDTH-1:0] Msg_score,
  output logic                          Busy
);
  localparam int unsigned Spc    = SAMPLES_PER_CHIP;
  localparam int unsigned WinLen = 16 * Spc;
  localparam int unsigned FillW  = $clog2(WinLen + 1);
  localparam int unsigned PhaseW = $clog2(2 * Spc);
  localparam int unsigned AccW   = MAG_WIDTH + 3;
  localparam int unsigned CmpW   =
      ((SCORE_WIDTH > THRESHOLD_WIDTH) ? SCORE_WIDTH : THRESHOLD_WIDTH) + 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StDecode = 1'b1;

  logic [MAG_WIDTH-1:0]          dl_q [WinLen];
  logic [MAG_WIDTH-1:0]          win  [WinLen];
  logic signed [SCORE_WIDTH-1:0] chip_sum [16];
  logic signed [SCORE_WIDTH-1:0] on_sum, off_sum, score;
  logic signed [CmpW-1:0]        score_cmp, thr_cmp;
  logic                          detect;

  logic [0:0]                    state_q, state_d;
  logic [FillW-1:0]              fill_q, fill_d;
  logic [PhaseW-1:0]             phase_q, phase_d;
  logic [AccW-1:0]               acc_first_q, acc_first_d, acc_second_q, acc_second_d;
  logic [AccW-1:0]               second_tot;
  logic [6:0]                    bit_cnt_q, bit_cnt_d;
  logic [110:0]                  shreg_q, shreg_d;
  logic [111:0]                  shift_next;
  logic                          long_q, long_d;
  logic signed [SCORE_WIDTH-1:0] score_lat_q, score_lat_d;
  logic                          bit_val, bit_done, last_bit;
  logic [4:0]                    df;

  logic                          msg_valid_q, msg_valid_d, msg_long_q, msg_long_d;
  logic [111:0]                  msg_data_q, msg_data_d;
  logic signed [SCORE_WIDTH-1:0] msg_score_q, msg_score_d;

  // Window as it will look once the incoming sample is shifted in; index 0 is the oldest.
  for (genvar j = 0; j < WinLen - 1; j++) begin : g_win
    assign win[j] = dl_q[j+1];
  end
  assign win[WinLen-1] = Mag_data;

  always_comb begin
    on_sum  = '0;
    off_sum = '0;
    for (int c = 0; c < 16; c++) begin
      chip_sum[c] = '0;
      for (int s = 0; s < Spc; s++) begin
        chip_sum[c] = chip_sum[c] + $signed({{(SCORE_WIDTH-MAG_WIDTH){1'b0}}, win[c*Spc+s]});
      end
      if (c == 0 || c == 2 || c == 7 || c == 9) on_sum = on_sum + chip_sum[c];
      else                                      off_sum = off_sum + chip_sum[c];
    end
    score = (on_sum <<< 1) + on_sum - off_sum;
  end

  assign score_cmp = {{(CmpW-SCORE_WIDTH){score[SCORE_WIDTH-1]}}, score};
  assign thr_cmp   = {{(CmpW-THRESHOLD_WIDTH){1'b0}}, Cfg_threshold};
  assign detect    = (state_q == StIdle) && Cfg_enable &&
                     (fill_q >= FillW'(WinLen - 1)) && (score_cmp > thr_cmp);

  assign second_tot = acc_second_q + AccW'(Mag_data);
  assign bit_done   = (phase_q == PhaseW'(2 * Spc - 1));
  assign bit_val    = acc_first_q > second_tot;
  assign shift_next = {shreg_q, bit_val};
  assign df         = shift_next[4:0];
  assign last_bit   = (bit_cnt_q == (long_q ? 7'd111 : 7'd55));

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    phase_d      = phase_q;
    acc_first_d  = acc_first_q;
    acc_second_d = acc_second_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    long_d       = long_q;
    score_lat_d  = score_lat_q;
    msg_valid_d  = 1'b0;
    msg_long_d   = msg_long_q;
    msg_data_d   = msg_data_q;
    msg_score_d  = msg_score_q;
    if (Mag_valid) begin
      case (state_q)
        StIdle: begin
          if (fill_q != FillW'(WinLen)) fill_d = fill_q + 1'b1;
          if (detect) begin
            state_d      = StDecode;
            phase_d      = '0;
            acc_first_d  = '0;
            acc_second_d = '0;
            bit_cnt_d    = '0;
            shreg_d      = '0;
            long_d       = 1'b0;
            score_lat_d  = score;
          end
        end
        default: begin
          phase_d = phase_q + 1'b1;
          if (phase_q < PhaseW'(Spc)) acc_first_d  = acc_first_q + AccW'(Mag_data);
          else                        acc_second_d = second_tot;
          if (bit_done) begin
            phase_d      = '0;
            acc_first_d  = '0;
            acc_second_d = '0;
            shreg_d      = shift_next[110:0];
            bit_cnt_d    = bit_cnt_q + 7'd1;
            if (bit_cnt_q == 7'd4) long_d = (df >= 5'd16);
            if (last_bit) begin
              // Refill the whole window before re-arming so message tail energy cannot trigger.
              state_d     = StIdle;
              fill_d      = '0;
              msg_valid_d = 1'b1;
              msg_long_d  = long_q;
              msg_data_d  = long_q ? shift_next : {shift_next[55:0], 56'd0};
              msg_score_d = score_lat_q;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int j = 0; j < WinLen; j++) dl_q[j] <= '0;
      state_q      <= StIdle;
      fill_q       <= '0;
      phase_q      <= '0;
      acc_first_q  <= '0;
      acc_second_q <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      long_q       <= 1'b0;
      score_lat_q  <= '0;
      msg_valid_q  <= 1'b0;
      msg_long_q   <= 1'b0;
      msg_data_q   <= '0;
      msg_score_q  <= '0;
    end else begin
      if (Mag_valid) begin
        for (int j = 0; j < WinLen; j++) dl_q[j] <= win[j];
      end
      state_q      <= state_d;
      fill_q       <= fill_d;
      phase_q      <= phase_d;
      acc_first_q  <= acc_first_d;
      acc_second_q <= acc_second_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      long_q       <= long_d;
      score_lat_q  <= score_lat_d;
      msg_valid_q  <= msg_valid_d;
      msg_long_q   <= msg_long_d;
      msg_data_q   <= msg_data_d;
      msg_score_q  <= msg_score_d;
    end
  end

  assign Msg_valid = msg_valid_q;
  assign Msg_long  = msg_long_q;
  assign Msg_data  = msg_data_q;
  assign Msg_score = msg_score_q;
  assign Busy      = (state_q == StDecode);

endmodule

// File: tb/tb_adsb_ppm_decoder.sv
// Randomised bench for adsb_ppm_decoder: sample streams are built as queues and an array-level
// reference model predicts every message, its score, its timing and the busy sample count.
module tb_adsb_ppm_decoder;
  localparam int unsigned MagW   = 16;
  localparam int unsigned Spc    = 2;
  localparam int unsigned ThrW   = 24;
  localparam int unsigned ScoreW = MagW + $clog2(Spc) + 6;
  localparam int          WinLen = 16 * Spc;
  localparam logic [111:0] PatL  = 112'h8D4840D6202CC371C32CE0576098;
  localparam logic [111:0] PatS  = {56'h5D4840D6202CC3, 56'h0};

  logic                     Clk = 1'b0;
  logic                     Rst = 1'b1;
  logic                     Mag_valid = 1'b0;
  logic [MagW-1:0]          Mag_data = '0;
  logic                     Cfg_enable = 1'b0;
  logic [ThrW-1:0]          Cfg_threshold = '0;
  logic                     Msg_valid, Msg_long, Busy;
  logic [111:0]             Msg_data;
  logic signed [ScoreW-1:0] Msg_score;

  adsb_ppm_decoder #(
    .MAG_WIDTH(MagW), .SAMPLES_PER_CHIP(Spc), .THRESHOLD_WIDTH(ThrW), .SCORE_WIDTH(ScoreW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Mag_valid(Mag_valid), .Mag_data(Mag_data),
    .Cfg_enable(Cfg_enable), .Cfg_threshold(Cfg_threshold), .Msg_valid(Msg_valid),
    .Msg_long(Msg_long), .Msg_data(Msg_data), .Msg_score(Msg_score), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int unsigned  s_mag[$];
  bit           s_en[$];
  int unsigned  s_thr[$];
  int           drv_cyc[$];
  logic [111:0] exp_data[$];
  bit           exp_long[$];
  longint       exp_score[$];
  int           exp_end[$];
  int           exp_busy;
  logic [111:0] got_data[$];
  bit           got_long[$];
  longint       got_score[$];
  int           got_cyc[$];
  int           busy_cnt;
  int           n_checks = 0;
  int           n_fail = 0;

  always @(negedge Clk) begin
    if (Msg_valid) begin
      got_data.push_back(Msg_data);
      got_long.push_back(Msg_long);
      got_score.push_back(longint'(Msg_score));
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_s(input int unsigned m, input bit en, input int unsigned thr);
    s_mag.push_back(m);
    s_en.push_back(en);
    s_thr.push_back(thr);
  endtask

  task automatic push_chip(input int unsigned lvl, input bit en, input int unsigned thr,
                           input int unsigned noise);
    for (int s = 0; s < Spc; s++) push_s(lvl + $urandom_range(noise, 0), en, thr);
  endtask

  task automatic push_preamble(input int unsigned hi, input bit en, input int unsigned thr,
                               input int unsigned noise);
    for (int c = 0; c < 16; c++)
      push_chip((c == 0 || c == 2 || c == 7 || c == 9) ? hi : 0, en, thr, noise);
  endtask

  task automatic push_msg(input logic [111:0] d, input int len, input int unsigned hi,
                          input bit en, input int unsigned thr, input int unsigned noise);
    for (int b = 0; b < len; b++) begin
      push_chip(d[111-b] ? hi : 0, en, thr, noise);
      push_chip(d[111-b] ? 0 : hi, en, thr, noise);
    end
  endtask

  function automatic longint chip_at(input int start);
    longint acc = 0;
    for (int s = 0; s < Spc; s++) acc += longint'(s_mag[start+s]);
    return acc;
  endfunction

  function automatic longint score_at(input int last);
    longint on = 0;
    longint off = 0;
    int base = last - WinLen + 1;
    for (int c = 0; c < 16; c++) begin
      if (c == 0 || c == 2 || c == 7 || c == 9) on += chip_at(base + c * Spc);
      else                                      off += chip_at(base + c * Spc);
    end
    return 3 * on - off;
  endfunction

  // Walks the first nsamp samples and lists every message that completes within them.
  task automatic model_run(input int nsamp);
    int i, fill;
    exp_data.delete(); exp_long.delete(); exp_score.delete(); exp_end.delete();
    exp_busy = 0;
    i = 0;
    fill = 0;
    while (i < nsamp) begin
      bit hit;
      hit = 1'b0;
      fill++;
      if (fill >= WinLen && s_en[i]) hit = (score_at(i) > longint'(s_thr[i]));
      if (hit) begin
        logic [111:0] d;
        int len, p;
        bit ok;
        d = '0; len = 56; p = i + 1; ok = 1'b1;
        for (int b = 0; b < len; b++) begin
          if (p + 2 * Spc > nsamp) begin
            ok = 1'b0;
            break;
          end
          d[111-b] = (chip_at(p) > chip_at(p + Spc));
          if (b == 4) len = (d[111:107] >= 5'd16) ? 112 : 56;
          p += 2 * Spc;
        end
        if (ok) begin
          exp_data.push_back(d);
          exp_long.push_back(len == 112);
          exp_score.push_back(score_at(i));
          exp_end.push_back(p - 1);
          exp_busy += p - i - 1;
          fill = 0;
          i = p;
        end else begin
          exp_busy += nsamp - i - 1;
          i = nsamp;
        end
      end else begin
        i++;
      end
    end
  endtask

  // Resets the DUT, plays the queued stream (optionally cut short by a reset) and compares.
  task automatic run(input string name, input int maxgap, input int abort_at);
    int nsamp, n;
    nsamp = (abort_at >= 0) ? abort_at : s_mag.size();
    @(negedge Clk);
    Rst = 1'b1;
    Mag_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    got_data.delete(); got_long.delete(); got_score.delete(); got_cyc.delete();
    drv_cyc.delete();
    busy_cnt = 0;
    for (int k = 0; k < nsamp; k++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        Mag_valid = 1'b0;
        Mag_data = MagW'($urandom);
        Cfg_enable = 1'($urandom);
        Cfg_threshold = ThrW'($urandom);
        @(negedge Clk);
      end
      Mag_valid = 1'b1;
      Mag_data = MagW'(s_mag[k]);
      Cfg_enable = s_en[k];
      Cfg_threshold = ThrW'(s_thr[k]);
      if (Busy) busy_cnt++;
      drv_cyc.push_back(cyc);
      @(negedge Clk);
    end
    if (abort_at >= 0) begin
      Rst = 1'b1;
      Mag_valid = 1'b1;
      Mag_data = MagW'($urandom);
      @(negedge Clk);
      Rst = 1'b0;
      Mag_valid = 1'b0;
      check({name, ":abort_busy"}, Busy, 0);
      check({name, ":abort_valid"}, Msg_valid, 0);
      check({name, ":abort_data"}, Msg_data, 0);
    end
    Mag_valid = 1'b0;
    repeat (4) @(negedge Clk);
    model_run(nsamp);
    check({name, ":count"}, got_data.size(), exp_data.size());
    check({name, ":busy"}, busy_cnt, exp_busy);
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int m = 0; m < n; m++) begin
      check({name, ":data"}, got_data[m], exp_data[m]);
      check({name, ":long"}, got_long[m], exp_long[m]);
      check({name, ":score"}, got_score[m], exp_score[m]);
      check({name, ":timing"}, got_cyc[m], drv_cyc[exp_end[m]] + 1);
    end
    s_mag.delete(); s_en.delete(); s_thr.delete();
  endtask

  initial begin
    logic [127:0] r128;
    logic [111:0] rnd;
    int unsigned  noise, hi, thr;
    bit           en;

    repeat (2) @(negedge Clk);
    check("rst_valid", Msg_valid, 0);
    check("rst_long", Msg_long, 0);
    check("rst_data", Msg_data, 0);
    check("rst_score", Msg_score, 0);
    check("rst_busy", Busy, 0);
    Rst = 1'b0;

    push_preamble(1000, 1, 500, 0);
    push_msg(PatL, 112, 1000, 1, 500, 0);
    run("ideal_long", 0, -1);
    check("ideal_count", got_data.size(), 1);
    if (got_data.size() > 0) begin
      check("ideal_score", got_score[0], 24000);
      check("ideal_data", got_data[0], PatL);
      check("ideal_flag", got_long[0], 1);
    end

    push_preamble(1000, 1, 500, 0);
    push_msg(PatS, 56, 1000, 1, 500, 0);
    run("short", 0, -1);
    check("short_busy_samples", busy_cnt, 56 * 2 * Spc);
    if (got_data.size() > 0) begin
      check("short_flag", got_long[0], 0);
      check("short_data", got_data[0], PatS);
    end

    for (int k = 0; k < 3 * WinLen; k++) push_s(1000, 1, 0);
    run("uniform", 0, -1);
    check("uniform_none", got_data.size(), 0);

    // Second preamble sits in the first message's data; the third follows the refill.
    r128 = {$urandom, $urandom, $urandom, $urandom};
    push_preamble(1000, 1, 500, 0);
    push_preamble(1000, 1, 500, 0);
    push_msg(r128[111:0], 104, 1000, 1, 500, 0);
    push_preamble(1000, 1, 500, 0);
    push_msg(PatL, 112, 1000, 1, 500, 0);
    run("back_to_back", 0, -1);
    check("b2b_count", got_data.size(), 2);

    push_preamble(1000, 1, 500, 0);
    push_msg(PatL, 112, 1000, 1, 500, 0);
    run("gaps", 5, -1);
    if (got_data.size() > 0) begin
      check("gaps_data", got_data[0], PatL);
      check("gaps_score", got_score[0], 24000);
    end

    push_preamble(1000, 1, 500, 0);
    push_msg(PatL, 112, 1000, 1, 500, 0);
    run("abort", 2, WinLen + 40 * 2 * Spc);
    check("abort_none", got_data.size(), 0);

    push_preamble(1000, 1, 500, 0);
    push_msg(PatL, 112, 1000, 1, 500, 0);
    run("after_abort", 1, -1);
    if (got_data.size() > 0) check("after_abort_data", got_data[0], PatL);

    push_preamble(1000, 0, 500, 0);
    push_msg(PatL, 112, 1000, 0, 500, 0);
    run("disabled", 0, -1);
    check("disabled_none", got_data.size(), 0);

    push_preamble(1000, 1, 500, 0);
    push_msg(PatS, 56, 1000, 0, 500, 0);
    run("enable_drop", 0, -1);
    check("enable_drop_count", got_data.size(), 1);

    for (int t = 0; t < 8; t++) begin
      noise = $urandom_range(300, 0);
      hi = $urandom_range(2000, 400);
      thr = $urandom_range(20000, 0);
      en = ($urandom_range(3, 0) != 0);
      r128 = {$urandom, $urandom, $urandom, $urandom};
      rnd = r128[111:0];
      for (int c = $urandom_range(20, 0); c > 0; c--) push_chip(0, 1'($urandom), thr, noise);
      push_preamble(hi, en, thr, noise);
      push_msg(rnd, rnd[111] ? 112 : 56, hi, 1'($urandom), thr, noise);
      for (int c = $urandom_range(20, 0); c > 0; c--) push_chip(0, 1'($urandom), thr, noise);
      run($sformatf("random%0d", t), 3, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
